// File: rtl/full_adder_checker.sv
// full_adder_checker
//   Response checker for the 1-bit full_adder. It sits at the observing end of
//   a self-test flow. Each accepted beat carries the stimulus that was applied
//   (a, b, cin) and the response the adder gave (sum, cout). For every beat the
//   checker compares the response with the expected value, counts vectors and
//   errors, and records which of the 8 input combinations have been seen. At
//   the end of a run it gives a single pass/done verdict.
//
// Optional feature:
//   `CHECKER_FIRST_FAIL_EN` adds first_fail_vld/first_fail. These latch the
//   first mismatching beat of a run as {a,b,cin,sum,cout}.
//
// Ports:
//   clk, rst          clock (rising edge); asynchronous active-high reset
//   start             one-cycle run request (ignored while a run is active)
//   in_valid/in_ready beat handshake; in_ready is high only while running
//   a, b, cin         stimulus applied to the adder
//   sum, cout         adder response
//   busy              run in progress
//   done, pass        run complete / verdict (held until next start or rst)
//   mismatch          one-cycle pulse after a mismatching beat
//   vec_count         beats accepted this run (saturating)
//   err_count         mismatching beats this run (saturating)
//   cov_mask          bit {a,b,cin} set once that combination was seen
module full_adder_checker #(
  parameter int N_VECTORS = 8,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a,
  input  logic             b,
  input  logic             cin,
  input  logic             sum,
  input  logic             cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [7:0]       cov_mask
`ifdef CHECKER_FIRST_FAIL_EN
  ,
  output logic             first_fail_vld,
  output logic [4:0]       first_fail
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [31:0]      LAST_IDX = 32'(N_VECTORS - 1);

  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic             start_run;
  logic             accept;
  logic             exp_sum;
  logic             exp_cout;
  logic             beat_bad;
  logic             last_beat;
  logic [2:0]       combo;
  logic [CNT_W-1:0] vec_next;
  logic [CNT_W-1:0] err_next;
  logic [7:0]       cov_next;

  assign busy     = (state_reg == ST_RUN);
  assign in_ready = busy;

  // start only matters outside RUN; a beat only counts inside RUN.
  assign start_run = start && (state_reg != ST_RUN);
  assign accept    = in_valid && (state_reg == ST_RUN);

  assign exp_sum  = a ^ b ^ cin;
  assign exp_cout = (a & b) | (a & cin) | (b & cin);
  assign beat_bad = ({sum, cout} != {exp_sum, exp_cout});
  assign combo    = {a, b, cin};

  // The final-beat test compares at 32 bits. If N_VECTORS does not fit in
  // CNT_W, the saturated counter can never reach it, so the run never ends.
  assign last_beat = accept && (32'(vec_count) == LAST_IDX);

  assign vec_next = (vec_count == CNT_MAX) ? vec_count : vec_count + CNT_W'(1);
  assign err_next = (beat_bad && (err_count != CNT_MAX)) ? err_count + CNT_W'(1)
                                                          : err_count;

  // One coverage bit per input combination.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_cov
      assign cov_next[gi] = cov_mask[gi] | (combo == 3'(gi));
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start)     state_next = ST_RUN;
      ST_RUN:  if (last_beat) state_next = ST_DONE;
      ST_DONE: if (start)     state_next = ST_RUN;
      default:                state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      done      <= 1'b0;
      pass      <= 1'b0;
      mismatch  <= 1'b0;
      vec_count <= '0;
      err_count <= '0;
      cov_mask  <= 8'h00;
    end else begin
      state_reg <= state_next;
      mismatch  <= accept && beat_bad;
      if (start_run) begin
        done      <= 1'b0;
        pass      <= 1'b0;
        vec_count <= '0;
        err_count <= '0;
        cov_mask  <= 8'h00;
      end else if (accept) begin
        vec_count <= vec_next;
        err_count <= err_next;
        cov_mask  <= cov_next;
        if (last_beat) begin
          done <= 1'b1;
          // The verdict uses the next-state values, so the final beat is included.
          pass <= (err_next == '0) && (cov_next == 8'hFF);
        end
      end
    end
  end

`ifdef CHECKER_FIRST_FAIL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_fail_vld <= 1'b0;
      first_fail     <= 5'b0;
    end else if (start_run) begin
      first_fail_vld <= 1'b0;
      first_fail     <= 5'b0;
    end else if (accept && beat_bad && !first_fail_vld) begin
      first_fail_vld <= 1'b1;
      first_fail     <= {a, b, cin, sum, cout};
    end
  end
`endif

endmodule

// File: tb/tb_full_adder_checker.sv
module tb_full_adder_checker;

  logic       clk = 1'b0;
  logic       rst, rst2;
  logic       start, start2;
  logic       in_valid, in_valid2;
  logic       a, b, cin, sum, cout;

  logic       in_ready, busy, done, pass, mismatch;
  logic [7:0] vec_count, err_count, cov_mask;
  logic       in_ready2, busy2, done2, pass2, mismatch2;
  logic [3:0] vec_count2, err_count2;
  logic [7:0] cov_mask2;
`ifdef CHECKER_FIRST_FAIL_EN
  logic       first_fail_vld, first_fail_vld2;
  logic [4:0] first_fail, first_fail2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  full_adder_checker #(.N_VECTORS(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
    .busy(busy), .done(done), .pass(pass), .mismatch(mismatch),
    .vec_count(vec_count), .err_count(err_count), .cov_mask(cov_mask)
`ifdef CHECKER_FIRST_FAIL_EN
    , .first_fail_vld(first_fail_vld), .first_fail(first_fail)
`endif
  );

  full_adder_checker #(.N_VECTORS(20), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst2), .start(start2), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
    .busy(busy2), .done(done2), .pass(pass2), .mismatch(mismatch2),
    .vec_count(vec_count2), .err_count(err_count2), .cov_mask(cov_mask2)
`ifdef CHECKER_FIRST_FAIL_EN
    , .first_fail_vld(first_fail_vld2), .first_fail(first_fail2)
`endif
  );

  typedef struct {
    logic [2:0] abc;
    logic       s;
    logic       c;
    logic       exp_mis;
  } vec_t;

  vec_t clean_tbl [8];
  vec_t fault_tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] abc, input logic s, input logic c);
    {a, b, cin} = abc;
    sum = s;
    cout = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    $display("beat abc=%b sum=%b cout=%b -> mismatch=%b vec=%0d err=%0d cov=%h",
             abc, s, c, mismatch, vec_count, err_count, cov_mask);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("ready_after_start", 32'(in_ready), 32'd1);
  endtask

  task automatic run_table(input string tag, input vec_t tbl [8]);
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].abc, tbl[i].s, tbl[i].c);
      check({tag, "_mismatch"}, 32'(mismatch), 32'(tbl[i].exp_mis));
      check({tag, "_vec"}, 32'(vec_count), 32'(i + 1));
    end
    in_valid = 1'b0;
  endtask

  initial begin
    // Hand-computed full adder truth table: sum 0,1,1,0,1,0,0,1 ; cout 0,0,0,1,0,1,1,1
    clean_tbl[0] = '{3'b000, 1'b0, 1'b0, 1'b0};
    clean_tbl[1] = '{3'b001, 1'b1, 1'b0, 1'b0};
    clean_tbl[2] = '{3'b010, 1'b1, 1'b0, 1'b0};
    clean_tbl[3] = '{3'b011, 1'b0, 1'b1, 1'b0};
    clean_tbl[4] = '{3'b100, 1'b1, 1'b0, 1'b0};
    clean_tbl[5] = '{3'b101, 1'b0, 1'b1, 1'b0};
    clean_tbl[6] = '{3'b110, 1'b0, 1'b1, 1'b0};
    clean_tbl[7] = '{3'b111, 1'b1, 1'b1, 1'b0};
    fault_tbl = clean_tbl;
    fault_tbl[3] = '{3'b011, 1'b1, 1'b1, 1'b1};  // sum wrong
    fault_tbl[6] = '{3'b110, 1'b1, 1'b1, 1'b1};  // later fault must not overwrite first capture

    rst = 1'b1; rst2 = 1'b1; start = 1'b0; start2 = 1'b0;
    in_valid = 1'b0; in_valid2 = 1'b0;
    {a, b, cin, sum, cout} = 5'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_mismatch", 32'(mismatch), 32'd0);
    check("rst_vec", 32'(vec_count), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_cov", 32'(cov_mask), 32'd0);
    rst = 1'b0;

    // Beats in IDLE are ignored.
    drive(3'b001, 1'b1, 1'b0);
    drive(3'b011, 1'b1, 1'b1);
    in_valid = 1'b0;
    check("idle_vec", 32'(vec_count), 32'd0);
    check("idle_cov", 32'(cov_mask), 32'd0);

    // Clean exhaustive run.
    pulse_start();
    run_table("clean", clean_tbl);
    check("clean_done", 32'(done), 32'd1);
    check("clean_pass", 32'(pass), 32'd1);
    check("clean_err", 32'(err_count), 32'd0);
    check("clean_cov", 32'(cov_mask), 32'hFF);
    check("clean_busy", 32'(busy), 32'd0);
    check("clean_ready", 32'(in_ready), 32'd0);
    // Beats after done are ignored.
    drive(3'b011, 1'b1, 1'b1);
    drive(3'b000, 1'b1, 1'b1);
    in_valid = 1'b0;
    check("after_done_vec", 32'(vec_count), 32'd8);
    check("after_done_err", 32'(err_count), 32'd0);
    check("after_done_mismatch", 32'(mismatch), 32'd0);

    // Restart from DONE clears everything.
    pulse_start();
    check("restart_done", 32'(done), 32'd0);
    check("restart_pass", 32'(pass), 32'd0);
    check("restart_vec", 32'(vec_count), 32'd0);
    check("restart_cov", 32'(cov_mask), 32'd0);

    // Injected faults.
    run_table("fault", fault_tbl);
    check("fault_err", 32'(err_count), 32'd2);
    check("fault_done", 32'(done), 32'd1);
    check("fault_pass", 32'(pass), 32'd0);
    check("fault_cov", 32'(cov_mask), 32'hFF);
`ifdef CHECKER_FIRST_FAIL_EN
    check("first_fail_vld", 32'(first_fail_vld), 32'd1);
    check("first_fail", 32'(first_fail), 32'b01111);
`endif

    // Missing coverage: all beats 000.
    pulse_start();
`ifdef CHECKER_FIRST_FAIL_EN
    check("first_fail_cleared", 32'(first_fail_vld), 32'd0);
`endif
    for (int i = 0; i < 8; i++) drive(3'b000, 1'b0, 1'b0);
    in_valid = 1'b0;
    check("cov_missing_mask", 32'(cov_mask), 32'h01);
    check("cov_missing_err", 32'(err_count), 32'd0);
    check("cov_missing_done", 32'(done), 32'd1);
    check("cov_missing_pass", 32'(pass), 32'd0);

    // Handshake gaps: in_valid alternates 1,0,1,...
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      {a, b, cin} = clean_tbl[i / 2].abc;
      sum = clean_tbl[i / 2].s;
      cout = clean_tbl[i / 2].c;
      in_valid = (i % 2 == 0);
      @(posedge clk);
      #1;
      $display("gap cycle %0d valid=%b vec=%0d", i, in_valid, vec_count);
      check("gap_vec", 32'(vec_count), 32'(i / 2 + 1));
    end
    in_valid = 1'b0;
    check("gap_done", 32'(done), 32'd1);
    check("gap_pass", 32'(pass), 32'd1);

    // Asynchronous reset mid-run.
    pulse_start();
    for (int i = 0; i < 3; i++) drive(fault_tbl[i + 1].abc, fault_tbl[i + 1].s, fault_tbl[i + 1].c);
    in_valid = 1'b0;
    check("pre_rst_vec", 32'(vec_count), 32'd3);
    check("pre_rst_mismatch", 32'(mismatch), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_vec", 32'(vec_count), 32'd0);
    check("async_rst_err", 32'(err_count), 32'd0);
    check("async_rst_cov", 32'(cov_mask), 32'd0);
    check("async_rst_mismatch", 32'(mismatch), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    pulse_start();
    check("post_rst_vec", 32'(vec_count), 32'd0);
    drive(3'b101, 1'b0, 1'b1);
    in_valid = 1'b0;
    check("post_rst_vec1", 32'(vec_count), 32'd1);

    // Saturation instance: 20 faulty beats, 4-bit counters.
    rst2 = 1'b0;
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    check("sat_busy", 32'(busy2), 32'd1);
    {a, b, cin, sum, cout} = 5'b00010;  // expected sum 0, driven 1
    for (int i = 0; i < 20; i++) begin
      in_valid2 = 1'b1;
      @(posedge clk);
      #1;
      $display("sat beat %0d vec=%0d err=%0d done=%b", i, vec_count2, err_count2, done2);
      check("sat_vec", 32'(vec_count2), 32'((i + 1 > 15) ? 15 : i + 1));
      check("sat_err", 32'(err_count2), 32'((i + 1 > 15) ? 15 : i + 1));
      check("sat_mismatch", 32'(mismatch2), 32'd1);
    end
    in_valid2 = 1'b0;
    check("sat_done", 32'(done2), 32'd0);
    check("sat_ready", 32'(in_ready2), 32'd1);
    #2 rst2 = 1'b1;
    #1;
    check("sat_rst_busy", 32'(busy2), 32'd0);
    check("sat_rst_vec", 32'(vec_count2), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
